// File: rtl/lsu_arbiter.sv
// lsu_arbiter: two-master arbiter in front of a single-port LSU with bus lock and 1-cycle responses.
// Define LSU_ARB_RR_EN for round-robin arbitration; the default build uses fixed priority (m0 wins).
module lsu_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_m0_req,
    input  logic [ADDR_W-1:0] i_m0_addr,
    input  logic [DATA_W-1:0] i_m0_wdata,
    input  logic [1:0]        i_m0_size,
    input  logic              i_m0_wren,
    input  logic              i_m0_lock,
    output logic              o_m0_gnt,
    output logic              o_m0_rvalid,
    output logic [DATA_W-1:0] o_m0_rdata,
    output logic              o_m0_err,
    input  logic              i_m1_req,
    input  logic [ADDR_W-1:0] i_m1_addr,
    input  logic [DATA_W-1:0] i_m1_wdata,
    input  logic [1:0]        i_m1_size,
    input  logic              i_m1_wren,
    input  logic              i_m1_lock,
    output logic              o_m1_gnt,
    output logic              o_m1_rvalid,
    output logic [DATA_W-1:0] o_m1_rdata,
    output logic              o_m1_err,
    output logic [ADDR_W-1:0] o_lsu_addr,
    output logic [DATA_W-1:0] o_lsu_st_data,
    output logic [1:0]        o_lsu_size,
    output logic              o_lsu_wren,
    input  logic [DATA_W-1:0] i_lsu_ld_data
);

    typedef enum logic [1:0] {
        UNLOCKED = 2'b00,
        LOCK_M0  = 2'b01,
        LOCK_M1  = 2'b10
    } lock_state_e;

    lock_state_e       state_r;
    lock_state_e       state_next_s;

    logic              req0_s;
    logic              req1_s;
    logic              gnt0_s;
    logic              gnt1_s;
    logic              any_gnt_s;
    logic [ADDR_W-1:0] win_addr_s;
    logic [DATA_W-1:0] win_wdata_s;
    logic [1:0]        win_size_s;
    logic              win_wren_s;
    logic              win_err_s;

    logic              rsp_valid_r;
    logic              rsp_owner_r;
    logic              rsp_err_r;
    logic              rsp_load_r;

    function automatic logic access_err(input logic [1:0] size, input logic [1:0] addr_lo);
        logic e;
        case (size)
            2'b00:   e = 1'b0;
            2'b01:   e = addr_lo[0];
            2'b10:   e = (addr_lo != 2'b00);
            default: e = 1'b1;
        endcase
        return e;
    endfunction

    // a lock owner shuts the other master out until it drops its lock
    assign req0_s    = i_m0_req & (state_r != LOCK_M1);
    assign req1_s    = i_m1_req & (state_r != LOCK_M0);
    assign any_gnt_s = gnt0_s | gnt1_s;

`ifdef LSU_ARB_RR_EN
    logic ptr_r;

    // round-robin tie break: pointer names the master that wins the next tie
    always_comb begin
        gnt0_s = 1'b0;
        gnt1_s = 1'b0;
        if (req0_s && req1_s) begin
            gnt0_s = ~ptr_r;
            gnt1_s = ptr_r;
        end else begin
            gnt0_s = req0_s;
            gnt1_s = req1_s;
        end
    end

    // pointer moves to the loser after every grant taken while unlocked
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            ptr_r <= 1'b0;
        end else if ((state_r == UNLOCKED) && any_gnt_s) begin
            ptr_r <= gnt0_s;
        end else begin
            ptr_r <= ptr_r;
        end
    end
`else
    // fixed priority: m0 always beats m1
    always_comb begin
        gnt0_s = req0_s;
        gnt1_s = req1_s & ~req0_s;
    end
`endif

    // winner mux; everything reads zero when nobody is granted
    always_comb begin
        win_addr_s  = {ADDR_W{1'b0}};
        win_wdata_s = {DATA_W{1'b0}};
        win_size_s  = 2'b00;
        win_wren_s  = 1'b0;
        if (gnt1_s) begin
            win_addr_s  = i_m1_addr;
            win_wdata_s = i_m1_wdata;
            win_size_s  = i_m1_size;
            win_wren_s  = i_m1_wren;
        end else if (gnt0_s) begin
            win_addr_s  = i_m0_addr;
            win_wdata_s = i_m0_wdata;
            win_size_s  = i_m0_size;
            win_wren_s  = i_m0_wren;
        end else begin
            win_addr_s  = {ADDR_W{1'b0}};
            win_wdata_s = {DATA_W{1'b0}};
            win_size_s  = 2'b00;
            win_wren_s  = 1'b0;
        end
    end

    assign win_err_s     = any_gnt_s & access_err(win_size_s, win_addr_s[1:0]);
    assign o_m0_gnt      = gnt0_s;
    assign o_m1_gnt      = gnt1_s;
    assign o_lsu_addr    = win_addr_s;
    assign o_lsu_st_data = win_wdata_s;
    assign o_lsu_size    = win_size_s;
    assign o_lsu_wren    = win_wren_s & ~win_err_s;

    // lock state register
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_r <= UNLOCKED;
        end else begin
            state_r <= state_next_s;
        end
    end

    // lock entry on a locked grant; exit on the first edge the owner's lock is low
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            UNLOCKED: begin
                if (gnt0_s && i_m0_lock) begin
                    state_next_s = LOCK_M0;
                end else if (gnt1_s && i_m1_lock) begin
                    state_next_s = LOCK_M1;
                end else begin
                    state_next_s = UNLOCKED;
                end
            end
            LOCK_M0: begin
                if (!i_m0_lock) begin
                    state_next_s = UNLOCKED;
                end else begin
                    state_next_s = LOCK_M0;
                end
            end
            LOCK_M1: begin
                if (!i_m1_lock) begin
                    state_next_s = UNLOCKED;
                end else begin
                    state_next_s = LOCK_M1;
                end
            end
            default: state_next_s = UNLOCKED;
        endcase
    end

    // response pipeline: exactly one pulse per grant, one cycle later
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            rsp_valid_r <= 1'b0;
            rsp_owner_r <= 1'b0;
            rsp_err_r   <= 1'b0;
            rsp_load_r  <= 1'b0;
        end else begin
            rsp_valid_r <= any_gnt_s;
            rsp_owner_r <= gnt1_s;
            rsp_err_r   <= win_err_s;
            rsp_load_r  <= any_gnt_s & ~win_wren_s & ~win_err_s;
        end
    end

    // load data arrives from the LSU in the response cycle, so it is steered, not stored
    assign o_m0_rvalid = rsp_valid_r & ~rsp_owner_r;
    assign o_m1_rvalid = rsp_valid_r & rsp_owner_r;
    assign o_m0_err    = o_m0_rvalid & rsp_err_r;
    assign o_m1_err    = o_m1_rvalid & rsp_err_r;
    assign o_m0_rdata  = (o_m0_rvalid && rsp_load_r) ? i_lsu_ld_data : {DATA_W{1'b0}};
    assign o_m1_rdata  = (o_m1_rvalid && rsp_load_r) ? i_lsu_ld_data : {DATA_W{1'b0}};

endmodule

// File: tb/tb_lsu_arbiter.sv
// Self-checking bench for lsu_arbiter: vector table, directed sequences and random traffic
// against a transaction-level reference model with its own memory image.
module tb_lsu_arbiter;

`ifdef LSU_ARB_RR_EN
    localparam bit RR_ON = 1'b1;
`else
    localparam bit RR_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        m_req [2];
    logic [31:0] m_addr [2];
    logic [31:0] m_wdata [2];
    logic [1:0]  m_size [2];
    logic        m_wren [2];
    logic        m_lock [2];
    logic        gnt [2];
    logic        rvalid [2];
    logic [31:0] rdata [2];
    logic        err [2];
    logic [31:0] lsu_addr;
    logic [31:0] lsu_st_data;
    logic [1:0]  lsu_size;
    logic        lsu_wren;
    logic [31:0] lsu_ld_data;
    logic [31:0] mem [256];

    always #5 clk = ~clk;

    lsu_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .i_clk(clk), .i_reset(rst_n),
        .i_m0_req(m_req[0]), .i_m0_addr(m_addr[0]), .i_m0_wdata(m_wdata[0]),
        .i_m0_size(m_size[0]), .i_m0_wren(m_wren[0]), .i_m0_lock(m_lock[0]),
        .o_m0_gnt(gnt[0]), .o_m0_rvalid(rvalid[0]), .o_m0_rdata(rdata[0]), .o_m0_err(err[0]),
        .i_m1_req(m_req[1]), .i_m1_addr(m_addr[1]), .i_m1_wdata(m_wdata[1]),
        .i_m1_size(m_size[1]), .i_m1_wren(m_wren[1]), .i_m1_lock(m_lock[1]),
        .o_m1_gnt(gnt[1]), .o_m1_rvalid(rvalid[1]), .o_m1_rdata(rdata[1]), .o_m1_err(err[1]),
        .o_lsu_addr(lsu_addr), .o_lsu_st_data(lsu_st_data), .o_lsu_size(lsu_size),
        .o_lsu_wren(lsu_wren), .i_lsu_ld_data(lsu_ld_data)
    );

    // LSU stub: word-wide synchronous memory, cleared while reset is held over an edge
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
        end else if (lsu_wren) begin
            mem[lsu_addr[9:2]] <= lsu_st_data;
        end
        lsu_ld_data <= mem[lsu_addr[9:2]];
    end

    int          n_vec = 0;
    int          n_err = 0;
    int          lock_owner;
    bit          favour;
    bit          pv;
    int          po;
    bit          pe;
    logic [31:0] pd;
    logic [31:0] ref_mem [256];
    bit          gnt_last [2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic bit is_bad(input logic [1:0] s, input logic [31:0] a);
        int unsigned bytes;
        if (s == 2'd3) return 1'b1;
        bytes = 1 << s;
        return (a % bytes) != 0;
    endfunction

    task automatic model_reset();
        lock_owner = -1;
        favour     = 1'b0;
        pv         = 1'b0;
        po         = 0;
        pe         = 1'b0;
        pd         = 32'h0;
        gnt_last[0] = 1'b0;
        gnt_last[1] = 1'b0;
        for (int i = 0; i < 256; i++) ref_mem[i] = 32'h0;
    endtask

    task automatic set_m(input int m, input logic r, input logic [31:0] a, input logic [1:0] s,
                         input logic w, input logic [31:0] d, input logic l);
        m_req[m] = r; m_addr[m] = a; m_size[m] = s; m_wren[m] = w; m_wdata[m] = d; m_lock[m] = l;
    endtask

    task automatic idle();
        for (int m = 0; m < 2; m++) set_m(m, 1'b0, 32'h0, 2'd0, 1'b0, 32'h0, 1'b0);
    endtask

    // one cycle: called at a negedge with inputs applied; compare, advance model, return at next negedge
    task automatic step();
        int          win;
        bit          r0, r1, bad;
        logic [31:0] ea, ed;
        logic [1:0]  es;
        logic        ew;
        #1;
        r0  = m_req[0] && (lock_owner != 1);
        r1  = m_req[1] && (lock_owner != 0);
        win = -1;
        if (r0 && r1) win = RR_ON ? int'(favour) : 0;
        else if (r0)  win = 0;
        else if (r1)  win = 1;
        ea = 32'h0; ed = 32'h0; es = 2'd0; ew = 1'b0; bad = 1'b0;
        if (win >= 0) begin
            bad = is_bad(m_size[win], m_addr[win]);
            ea = m_addr[win]; ed = m_wdata[win]; es = m_size[win];
            ew = m_wren[win] && !bad;
        end
        chk("gnt0", 32'(gnt[0]), 32'(win == 0));
        chk("gnt1", 32'(gnt[1]), 32'(win == 1));
        chk("lsu_addr", lsu_addr, ea);
        chk("lsu_st_data", lsu_st_data, ed);
        chk("lsu_size", 32'(lsu_size), 32'(es));
        chk("lsu_wren", 32'(lsu_wren), 32'(ew));
        for (int m = 0; m < 2; m++) begin
            chk("rvalid", 32'(rvalid[m]), 32'(pv && po == m));
            chk("rdata", rdata[m], (pv && po == m) ? pd : 32'h0);
            chk("err", 32'(err[m]), 32'(pv && po == m && pe));
        end
        @(posedge clk);
        pv = (win >= 0); po = win; pe = bad; pd = 32'h0;
        if (win >= 0 && !bad) begin
            if (m_wren[win]) ref_mem[m_addr[win][9:2]] = m_wdata[win];
            else             pd = ref_mem[m_addr[win][9:2]];
        end
        if (lock_owner < 0) begin
            if (win >= 0) begin
                if (m_lock[win]) lock_owner = win;
                favour = (win == 0);
            end
        end else if (!m_lock[lock_owner]) begin
            lock_owner = -1;
        end
        gnt_last[0] = (win == 0);
        gnt_last[1] = (win == 1);
        @(negedge clk);
    endtask

    // called at a negedge; holds reset over one rising edge and checks the all-zero outputs
    task automatic pulse_reset();
        idle();
        rst_n = 1'b0;
        #1;
        for (int m = 0; m < 2; m++) begin
            chk("rst_gnt", 32'(gnt[m]), 32'h0);
            chk("rst_rvalid", 32'(rvalid[m]), 32'h0);
            chk("rst_rdata", rdata[m], 32'h0);
            chk("rst_err", 32'(err[m]), 32'h0);
        end
        chk("rst_lsu_addr", lsu_addr, 32'h0);
        chk("rst_lsu_wren", 32'(lsu_wren), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    typedef struct {
        logic        r0; logic [31:0] a0; logic [1:0] s0; logic w0;
        logic        r1; logic [31:0] a1; logic [1:0] s1; logic w1;
        logic        eg0; logic eg1; logic ewren; logic eerr;
    } vec_t;

    vec_t        tbl [9];
    logic [31:0] bdata [10];
    int          prev_g;
    logic        prev_err;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        model_reset();
        @(negedge clk);
        pulse_reset();

        tbl[0] = '{1'b1, 32'h40, 2'd2, 1'b1, 1'b0, 32'h0,  2'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[1] = '{1'b0, 32'h0,  2'd0, 1'b0, 1'b1, 32'h41, 2'd1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[2] = '{1'b1, 32'h0,  2'd3, 1'b0, 1'b0, 32'h0,  2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[3] = '{1'b0, 32'h0,  2'd0, 1'b0, 1'b1, 32'h43, 2'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[4] = '{1'b1, 32'h4,  2'd2, 1'b0, 1'b1, 32'h8,  2'd2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[5] = '{1'b1, 32'h40, 2'd2, 1'b0, 1'b1, 32'h8,  2'd2, 1'b0, !RR_ON, RR_ON, 1'b0, 1'b0};
        tbl[6] = '{1'b1, 32'h46, 2'd1, 1'b1, 1'b0, 32'h0,  2'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[7] = '{1'b0, 32'h0,  2'd0, 1'b0, 1'b1, 32'h42, 2'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[8] = '{1'b0, 32'h0,  2'd0, 1'b0, 1'b0, 32'h0,  2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        prev_g = -1;
        prev_err = 1'b0;
        for (int i = 0; i < 9; i++) begin
            set_m(0, tbl[i].r0, tbl[i].a0, tbl[i].s0, tbl[i].w0, 32'hA5A5_0000 + 32'(i), 1'b0);
            set_m(1, tbl[i].r1, tbl[i].a1, tbl[i].s1, tbl[i].w1, 32'h5A5A_0000 + 32'(i), 1'b0);
            #1;
            chk("tbl_gnt0", 32'(gnt[0]), 32'(tbl[i].eg0));
            chk("tbl_gnt1", 32'(gnt[1]), 32'(tbl[i].eg1));
            chk("tbl_lsu_wren", 32'(lsu_wren), 32'(tbl[i].ewren));
            if (prev_g >= 0) begin
                chk("tbl_rvalid", 32'(rvalid[prev_g]), 32'h1);
                chk("tbl_err", 32'(err[prev_g]), 32'(prev_err));
            end
            prev_g   = tbl[i].eg0 ? 0 : (tbl[i].eg1 ? 1 : -1);
            prev_err = tbl[i].eerr;
            step();
        end

        // store then load
        set_m(0, 1'b1, 32'h10, 2'd2, 1'b1, 32'hCAFE_F00D, 1'b0); step();
        set_m(0, 1'b1, 32'h10, 2'd2, 1'b0, 32'h0, 1'b0);         step();
        idle(); #1;
        chk("sl_rvalid", 32'(rvalid[0]), 32'h1);
        chk("sl_rdata", rdata[0], 32'hCAFE_F00D);
        chk("sl_err", 32'(err[0]), 32'h0);
        step();

        // tie from a fresh pointer
        pulse_reset();
        for (int i = 0; i < 4; i++) begin
            set_m(0, 1'b1, 32'h4, 2'd2, 1'b0, 32'h0, 1'b0);
            set_m(1, 1'b1, 32'h8, 2'd2, 1'b0, 32'h0, 1'b0);
            #1;
            chk("tie_gnt0", 32'(gnt[0]), 32'(RR_ON ? (i % 2 == 0) : 1'b1));
            chk("tie_gnt1", 32'(gnt[1]), 32'(RR_ON ? (i % 2 == 1) : 1'b0));
            step();
        end
        idle(); step();

        // m1 locks for three stores while m0 waits with a load of 0x20
        set_m(1, 1'b1, 32'h20, 2'd2, 1'b1, 32'h2020_0020, 1'b1); step();
        set_m(1, 1'b1, 32'h24, 2'd2, 1'b1, 32'h2424_0024, 1'b1);
        set_m(0, 1'b1, 32'h20, 2'd2, 1'b0, 32'h0, 1'b0);
        #1; chk("lock_stall_m0", 32'(gnt[0]), 32'h0);
        step();
        set_m(1, 1'b1, 32'h28, 2'd2, 1'b1, 32'h2828_0028, 1'b0);
        #1;
        chk("lock_last_m1", 32'(gnt[1]), 32'h1);
        chk("lock_still_stall", 32'(gnt[0]), 32'h0);
        step();
        set_m(1, 1'b0, 32'h0, 2'd0, 1'b0, 32'h0, 1'b0);
        #1; chk("lock_release_m0", 32'(gnt[0]), 32'h1);
        step();
        idle(); #1;
        chk("lock_m0_rdata", rdata[0], 32'h2020_0020);
        step();

        // misaligned half store must not disturb the word at 0x30
        set_m(0, 1'b1, 32'h30, 2'd2, 1'b1, 32'h1122_3344, 1'b0); step();
        set_m(0, 1'b1, 32'h33, 2'd1, 1'b1, 32'hDEAD_BEEF, 1'b0);
        #1;
        chk("mis_gnt", 32'(gnt[0]), 32'h1);
        chk("mis_wren", 32'(lsu_wren), 32'h0);
        step();
        set_m(0, 1'b1, 32'h30, 2'd2, 1'b0, 32'h0, 1'b0);
        #1;
        chk("mis_rvalid", 32'(rvalid[0]), 32'h1);
        chk("mis_err", 32'(err[0]), 32'h1);
        step();
        idle(); #1;
        chk("mis_reload", rdata[0], 32'h1122_3344);
        step();

        // back-to-back stores then loads from m1
        for (int i = 0; i < 10; i++) begin
            bdata[i] = $urandom;
            set_m(1, 1'b1, 32'(4 * i), 2'd2, 1'b1, bdata[i], 1'b0);
            step();
        end
        for (int i = 0; i < 11; i++) begin
            if (i < 10) set_m(1, 1'b1, 32'(4 * i), 2'd2, 1'b0, 32'h0, 1'b0);
            else        idle();
            #1;
            if (i > 0) begin
                chk("b2b_rvalid", 32'(rvalid[1]), 32'h1);
                chk("b2b_rdata", rdata[1], bdata[i-1]);
            end
            step();
        end

        // reset hits the response cycle of a locking m0 load
        set_m(0, 1'b1, 32'h10, 2'd2, 1'b0, 32'h0, 1'b1); step();
        pulse_reset();
        set_m(0, 1'b1, 32'h4, 2'd2, 1'b0, 32'h0, 1'b0);
        set_m(1, 1'b1, 32'h8, 2'd2, 1'b0, 32'h0, 1'b0);
        #1; chk("rst_tie_m0", 32'(gnt[0]), 32'h1);
        step();
        idle(); step();

        // reset while m1 holds the lock must reopen arbitration
        set_m(1, 1'b1, 32'h8, 2'd2, 1'b0, 32'h0, 1'b1); step();
        set_m(1, 1'b0, 32'h0, 2'd0, 1'b0, 32'h0, 1'b1);
        pulse_reset();
        set_m(0, 1'b1, 32'h4, 2'd2, 1'b0, 32'h0, 1'b0);
        #1; chk("rst_unlock_m0", 32'(gnt[0]), 32'h1);
        step();
        idle(); step();

        // random traffic; a stalled master holds its request unchanged
        for (int c = 0; c < 400; c++) begin
            for (int m = 0; m < 2; m++) begin
                if (!(m_req[m] && !gnt_last[m])) begin
                    set_m(m, $urandom_range(0, 3) != 0,
                          32'($urandom_range(0, 1023)),
                          ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2)),
                          1'($urandom_range(0, 1)),
                          $urandom,
                          $urandom_range(0, 3) == 0);
                end
            end
            step();
        end
        idle(); step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
